// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter that multiplexes NUM_REQ writers onto one FIFO write port.
// A grant is held for up to BURST_MAX words; half-full admits only prio_mask requesters to new grants.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ-1:0]            prio_mask,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_wfull,
    input  logic                          fifo_half_full,
    output logic                          write_enable,
    output logic [DATA_WIDTH-1:0]         data_write,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [15:0]                   stall_cnt
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d, last_q, last_d, pick;
    logic [3:0]      beat_q, beat_d;
    logic [15:0]     stall_q, stall_d;
    logic [NUM_REQ-1:0] elig;
    logic            found, own_valid, xfer, done;

    assign elig = req_valid & (fifo_half_full ? prio_mask : '1);

    // search starts one past the previous owner so every requester gets a turn
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && elig[(int'(last_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick  = GW'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    assign busy         = (state_q == BURST);
    assign own_valid    = req_valid[grant_q];
    assign xfer         = busy & own_valid & !fifo_wfull;
    assign write_enable = xfer;
    assign req_ready    = (busy && !fifo_wfull) ? (NUM_REQ'(1) << grant_q) : '0;
    assign data_write   = xfer ? req_data[grant_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign grant_id     = grant_q;
    assign stall_cnt    = stall_q;

    // a full FIFO never ends a burst; only last, beat limit or owner withdrawal do
    assign done = (xfer & (req_last[grant_q] | (beat_q == 4'(BURST_MAX - 1))))
                | (busy & !own_valid & !fifo_wfull);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beat_d  = xfer ? beat_q + 4'd1 : beat_q;
        stall_d = (busy && fifo_wfull && own_valid && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = BURST;
                grant_d = pick;
                beat_d  = '0;
            end
        end else if (done) begin
            state_d = IDLE;
            last_d  = grant_q;
        end
    end

    always_ff @(posedge clk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            beat_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of grant order, burst length, stalls, half-full gating and reset.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          wrst_n = 1'b0;
    logic [N-1:0]  req_valid = '0, req_last = '0, prio_mask = '0, req_ready;
    logic [N*DW-1:0] req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    logic          fifo_wfull = 1'b0, fifo_half_full = 1'b0;
    logic          write_enable, busy;
    logic [DW-1:0] data_write;
    logic [1:0]    grant_id;
    logic [15:0]   stall_cnt;
    int            n_tests = 0, n_fail = 0;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(4)) dut (
        .clk(clk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .prio_mask(prio_mask), .req_ready(req_ready),
        .fifo_wfull(fifo_wfull), .fifo_half_full(fifo_half_full),
        .write_enable(write_enable), .data_write(data_write), .grant_id(grant_id),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        req_valid = '0; req_last = '0; prio_mask = '0;
        fifo_wfull = 1'b0; fifo_half_full = 1'b0;
        #1;
        check("rst we", write_enable, 0);
        check("rst busy", busy, 0);
        check("rst ready", req_ready, 0);
        check("rst data", data_write, 0);
        check("rst grant", grant_id, 0);
        check("rst stall", stall_cnt, 0);
        cyc();
        cyc();
        wrst_n = 1'b1;
    endtask

    initial begin
        int  wc;
        logic exp_we;
        logic [1:0] eg;
        // all valid, two-word bursts: 0,1,2,3,0 with one idle cycle between
        do_reset();
        req_valid = '1;
        wc = 0;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) cyc();
            req_last = {N{wc[0]}};
            #1;
            exp_we = (c % 3) != 0;
            eg = 2'(((c - 1) / 3) % 4);
            check($sformatf("rr we c%0d", c), write_enable, exp_we);
            check($sformatf("rr busy c%0d", c), busy, exp_we);
            if (exp_we) begin
                check($sformatf("rr grant c%0d", c), grant_id, eg);
                check($sformatf("rr data c%0d", c), data_write, 8'hA0 + eg);
            end
            wc += int'(write_enable);
        end
        // no last: four words then the next valid requester; half-full mid-burst does not cut it
        do_reset();
        req_valid = 4'b0110;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) cyc();
            if (c == 2) begin
                fifo_half_full = 1'b1;
                prio_mask = 4'b0100;
            end
            #1;
            exp_we = (c >= 1 && c <= 4) || c == 6;
            check($sformatf("bmax we c%0d", c), write_enable, exp_we);
            if (exp_we) check($sformatf("bmax grant c%0d", c), grant_id, (c == 6) ? 2 : 1);
        end
        // five full cycles mid-burst: stall counted, grant held, then resume
        do_reset();
        req_valid = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) cyc();
            fifo_wfull = (c >= 2 && c <= 6);
            #1;
            exp_we = (c >= 1) && !fifo_wfull;
            check($sformatf("stall we c%0d", c), write_enable, exp_we);
            check($sformatf("stall ready c%0d", c), req_ready, exp_we ? 4'b0001 : 4'b0000);
            check($sformatf("stall busy c%0d", c), busy, c >= 1);
            if (c >= 1) check($sformatf("stall grant c%0d", c), grant_id, 0);
            check($sformatf("stall cnt c%0d", c), stall_cnt, (c <= 2) ? 0 : (c >= 7) ? 5 : c - 2);
        end
        // half full: only prio requester 2, then round-robin resumes at 3
        do_reset();
        req_valid = '1; req_last = '1;
        fifo_half_full = 1'b1; prio_mask = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) cyc();
            if (c == 4) fifo_half_full = 1'b0;
            #1;
            exp_we = c[0];
            check($sformatf("hf we c%0d", c), write_enable, exp_we);
            if (exp_we) check($sformatf("hf grant c%0d", c), grant_id, (c < 4) ? 2 : (c == 5) ? 3 : 0);
        end
        // reset mid-burst after two words
        do_reset();
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) cyc();
            #1;
            check($sformatf("mr we c%0d", c), write_enable, c >= 1);
            if (c >= 1) check($sformatf("mr grant c%0d", c), grant_id, 1);
        end
        cyc();
        wrst_n = 1'b0;
        #1;
        check("mr we async", write_enable, 0);
        check("mr busy async", busy, 0);
        check("mr ready async", req_ready, 0);
        check("mr data async", data_write, 0);
        check("mr grant async", grant_id, 0);
        req_valid = 4'b0011;
        for (int c = 0; c < 2; c++) begin
            cyc();
            check($sformatf("mr held we %0d", c), write_enable, 0);
        end
        cyc();
        wrst_n = 1'b1;
        #1;
        check("mr rel idle we", write_enable, 0);
        cyc();
        #1;
        check("mr first we", write_enable, 1);
        check("mr first grant", grant_id, 0);
        // owner withdraws: burst ends, last_grant advances past it
        do_reset();
        req_valid = 4'b0111;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) cyc();
            if (c == 2) req_valid = 4'b0110;
            if (c == 3) req_valid = 4'b0111;
            #1;
            check($sformatf("drop we c%0d", c), write_enable, c == 1 || c == 4);
            check($sformatf("drop busy c%0d", c), busy, c == 1 || c == 2 || c == 4);
            if (c == 1) check("drop grant0", grant_id, 0);
            if (c == 4) check("drop grant1", grant_id, 1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
